// File: rtl/vga_capture_if.sv
// vga_capture_if: pixel-stream and frame-store write bundle for the VGA capture sink.
// master: drives the video stream and observes the frame-store writes (VGA source side).
// slave:  receives the video stream and issues the frame-store writes (capture side).
interface vga_capture_if #(
  parameter int unsigned H_BITS = 10,
  parameter int unsigned V_BITS = 9
);

  // Video stream, pixel-clock synchronous
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  // Frame-store write port; address packs {h, v} like the display-side memory
  logic                       wr_en;
  logic [H_BITS+V_BITS-1:0]   wr_addr;
  logic [23:0]                wr_data;

  modport master (
    output vga_hsync,
    output vga_vsync,
    output vga_blank_n,
    output vga_r,
    output vga_g,
    output vga_b,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  vga_hsync,
    input  vga_vsync,
    input  vga_blank_n,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/vga_capture.sv
// vga_capture: VGA sink. Recovers active-pixel coordinates by counting blank_n-qualified
// pixels between line ends and vsync edges, and writes each active pixel into a frame store
// at {h, v}. Malformed frames raise err and drop lock; well-formed frames pulse frame_done.
// Optional build macro VGA_CAPTURE_SUM_EN adds frame_sum, the mod-2^24 sum of a frame's pixels.
module vga_capture #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned H_BITS          = 10,
  parameter int unsigned V_BITS          = 9,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  vga_capture_if.slave bus,
  output logic         frame_done,
  output logic         locked,
  output logic         err
`ifdef VGA_CAPTURE_SUM_EN
  ,
  output logic [23:0]  frame_sum
`endif
);

  // Counters carry one extra bit so they can hold H_ACTIVE / V_ACTIVE and saturate there.
  localparam logic [H_BITS:0] HMax = (H_BITS + 1)'(H_ACTIVE);
  localparam logic [V_BITS:0] VMax = (V_BITS + 1)'(V_ACTIVE);
  localparam logic [H_BITS:0] HOne = (H_BITS + 1)'(1);
  localparam logic [V_BITS:0] VOne = (V_BITS + 1)'(1);

  typedef enum logic [1:0] {
    StUnlocked,
    StArmed,
    StCapture
  } state_e;

  state_e                   state_q;
  logic [H_BITS:0]          h_cnt_q;
  logic [V_BITS:0]          v_cnt_q;
  logic                     line_bad_q;
  logic                     vs_prev_q;
  logic                     blank_prev_q;

  logic                     wr_en_q;
  logic [H_BITS+V_BITS-1:0] wr_addr_q;
  logic [23:0]              wr_data_q;
  logic                     frame_done_q;
  logic                     locked_q;
  logic                     err_q;

  logic                     vs_act;
  logic                     hs_act;
  logic                     blank;
  logic                     vs_edge;
  logic                     line_end;
  logic                     in_range;
  logic                     line_ok;
  logic [V_BITS:0]          v_next;
  logic                     pix_wr;
  logic                     frame_ok;
  logic [23:0]              pixel;

  // Sync decode: a sync is "active" while it sits at its pulse level.
  always_comb begin
    vs_act   = bus.vga_vsync ^ SYNC_ACTIVE_LOW;
    hs_act   = bus.vga_hsync ^ SYNC_ACTIVE_LOW;
    blank    = bus.vga_blank_n;
    pixel    = {bus.vga_r, bus.vga_g, bus.vga_b};
    vs_edge  = vs_act & ~vs_prev_q;
    line_end = ~blank & blank_prev_q;
  end

  // Per-cycle decisions shared by the FSM and the optional frame accumulator.
  always_comb begin
    in_range = (h_cnt_q < HMax) && (v_cnt_q < VMax);
    line_ok  = (h_cnt_q == HMax) && !line_bad_q;
    v_next   = (v_cnt_q == VMax) ? v_cnt_q : v_cnt_q + VOne;
    // A pixel coinciding with vsync or hsync is a framing error and is never stored.
    pix_wr   = (state_q != StUnlocked) && blank && !vs_edge && !hs_act && in_range;
    // Frame is complete when vsync arrives with every line closed cleanly.
    frame_ok = (state_q == StCapture) && vs_edge && !blank &&
               !(line_end && !line_ok) &&
               ((line_end ? v_next : v_cnt_q) == VMax);
  end

  // Capture FSM with registered write port and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StUnlocked;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      line_bad_q   <= 1'b0;
      vs_prev_q    <= 1'b0;
      blank_prev_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      vs_prev_q    <= vs_act;
      blank_prev_q <= blank;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;

      if (pix_wr) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= {h_cnt_q[H_BITS-1:0], v_cnt_q[V_BITS-1:0]};
        wr_data_q <= pixel;
      end

      unique case (state_q)
        StUnlocked: begin
          if (vs_edge) begin
            state_q    <= StArmed;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            line_bad_q <= 1'b0;
          end
        end

        StArmed: begin
          h_cnt_q    <= '0;
          v_cnt_q    <= '0;
          line_bad_q <= 1'b0;
          if (blank) begin
            if (vs_edge) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
            end else if (hs_act) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= StUnlocked;
            end else begin
              h_cnt_q <= HOne;
              state_q <= StCapture;
            end
          end
        end

        StCapture: begin
          if (vs_edge) begin
            // Any vsync resyncs straight to ARMED; only a full frame counts as done.
            state_q    <= StArmed;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            line_bad_q <= 1'b0;
            if (frame_ok) begin
              frame_done_q <= 1'b1;
              locked_q     <= 1'b1;
            end else begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
            end
          end else if (line_end) begin
            if (line_ok) begin
              h_cnt_q    <= '0;
              v_cnt_q    <= v_next;
              line_bad_q <= 1'b0;
            end else begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= StUnlocked;
            end
          end else if (blank) begin
            if (hs_act) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= StUnlocked;
            end else if (in_range) begin
              h_cnt_q <= h_cnt_q + HOne;
            end else begin
              line_bad_q <= 1'b1;
            end
          end
        end

        default: state_q <= StUnlocked;
      endcase
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign frame_done  = frame_done_q;
  assign locked      = locked_q;
  assign err         = err_q;

`ifdef VGA_CAPTURE_SUM_EN
  logic [23:0] sum_q;
  logic [23:0] frame_sum_q;

  // Running pixel sum, restarted while ARMED and published when a frame completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      sum_q <= ((state_q == StArmed) ? 24'd0 : sum_q) + (pix_wr ? pixel : 24'd0);
      if (frame_ok) begin
        frame_sum_q <= sum_q;
      end
    end
  end

  assign frame_sum = frame_sum_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed bench for vga_capture (8x4 active, active-low syncs).
// A frame-level model predicts every output each cycle; literal checks pin the model.
module tb_vga_capture;

  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;
  localparam int unsigned HB = 10;
  localparam int unsigned VB = 9;

  logic clk = 1'b0;
  logic rst;
  logic frame_done;
  logic locked;
  logic err;
`ifdef VGA_CAPTURE_SUM_EN
  logic [23:0] frame_sum;
`endif

  vga_capture_if #(.H_BITS(HB), .V_BITS(VB)) bus ();

  vga_capture #(
    .H_ACTIVE       (HA),
    .V_ACTIVE       (VA),
    .H_BITS         (HB),
    .V_BITS         (VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_done(frame_done),
    .locked    (locked),
    .err       (err)
`ifdef VGA_CAPTURE_SUM_EN
    ,
    .frame_sum (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int h, input int v);
    logic [7:0] a;
    logic [7:0] b;
    a = h[7:0];
    b = v[7:0];
    return {a, b, a ^ b ^ 8'h5A};
  endfunction

  // Frame-level model: position (x, y) within the frame, whether a frame is in progress.
  bit          m_in = 0, m_started = 0, m_bad = 0, m_locked = 0, m_vsp = 0, m_blp = 0;
  int          m_x = 0, m_y = 0;
  logic [23:0] m_sum = '0, m_fsum = '0;
  bit          e_wr = 0, e_fd = 0, e_err = 0, e_locked = 0;
  logic [18:0] e_addr = '0;
  logic [23:0] e_data = '0;

  initial begin : model
    bit          vs_a, hs_a, bl, vs_e, le;
    logic [23:0] pix;
    forever begin
      @(posedge clk);
      e_wr  = 0;
      e_fd  = 0;
      e_err = 0;
      if (!rst) begin
        m_in = 0; m_started = 0; m_bad = 0; m_locked = 0; m_vsp = 0; m_blp = 0;
        m_x = 0; m_y = 0; m_sum = '0; m_fsum = '0;
      end else begin
        vs_a = !bus.vga_vsync;
        hs_a = !bus.vga_hsync;
        bl   = bus.vga_blank_n;
        pix  = {bus.vga_r, bus.vga_g, bus.vga_b};
        vs_e = vs_a && !m_vsp;
        le   = !bl && m_blp;
        m_vsp = vs_a;
        m_blp = bl;
        if (m_in && !m_started) m_sum = '0;
        if (!m_in) begin
          if (vs_e) begin
            m_in = 1; m_started = 0; m_x = 0; m_y = 0; m_bad = 0;
          end
        end else if (vs_e) begin
          if (bl) e_err = 1;
          else if (m_started) begin
            if (m_y == int'(VA)) begin
              e_fd = 1; m_locked = 1; m_fsum = m_sum;
            end else e_err = 1;
          end
          m_started = 0; m_x = 0; m_y = 0; m_bad = 0;
        end else if (le && m_started) begin
          if (m_x != int'(HA) || m_bad) begin
            e_err = 1; m_in = 0;
          end else begin
            m_x = 0;
            if (m_y < int'(VA)) m_y++;
          end
        end else if (bl) begin
          if (hs_a) begin
            e_err = 1; m_in = 0;
          end else if (m_x < int'(HA) && m_y < int'(VA)) begin
            e_wr = 1; e_addr = {m_x[9:0], m_y[8:0]}; e_data = pix;
            m_sum = m_sum + pix; m_x++; m_started = 1;
          end else m_bad = 1;
        end
        if (e_err) m_locked = 0;
      end
      e_locked = m_locked;
    end
  end

  // Observed activity, used by the literal checks.
  int          n_wr = 0, n_fd = 0, n_err = 0;
  logic [18:0] wq[$];

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("wr_en", bus.wr_en, e_wr);
      if (e_wr) begin
        chk("wr_addr", bus.wr_addr, e_addr);
        chk("wr_data", bus.wr_data, e_data);
      end
      chk("frame_done", frame_done, e_fd);
      chk("err", err, e_err);
      chk("locked", locked, e_locked);
`ifdef VGA_CAPTURE_SUM_EN
      chk("frame_sum", frame_sum, m_fsum);
`endif
      if (bus.wr_en === 1'b1) begin
        n_wr++;
        wq.push_back(bus.wr_addr);
      end
      if (frame_done === 1'b1) n_fd++;
      if (err === 1'b1) n_err++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.vga_blank_n = 1'b0;
      bus.vga_hsync   = 1'b1;
      bus.vga_vsync   = 1'b1;
    end
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.vga_blank_n = 1'b0;
      bus.vga_vsync   = 1'b0;
    end
    idle(2);
  endtask

  // One line of n pixels, then blanking with an hsync pulse; rst_at >= 0 drops rst on that pixel.
  task automatic line(input int n, input int v, input bit ones, input int rst_at);
    for (int h = 0; h < n; h++) begin
      @(negedge clk);
      if (h == rst_at + 1 && rst_at >= 0) begin
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_addr", bus.wr_addr, 19'd0);
      end
      bus.vga_blank_n = 1'b1;
      bus.vga_hsync   = 1'b1;
      {bus.vga_r, bus.vga_g, bus.vga_b} = ones ? 24'hFFFFFF : pat(h, v);
      rst = (h == rst_at) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    bus.vga_blank_n = 1'b0;
    bus.vga_hsync   = 1'b0;
    idle(2);
  endtask

  int w0, e0, wf;

  initial begin : stim
    rst = 1'b0;
    bus.vga_hsync   = 1'b1;
    bus.vga_vsync   = 1'b1;
    bus.vga_blank_n = 1'b0;
    {bus.vga_r, bus.vga_g, bus.vga_b} = '0;
    idle(3);
    chk("reset_wr_en", bus.wr_en, 1'b0);
    chk("reset_wr_data", bus.wr_data, 24'd0);
    chk("reset_locked", locked, 1'b0);
    chk("reset_fd", frame_done, 1'b0);
    rst = 1'b1;

    // Pixels before any vsync must not be written.
    line(8, 0, 0, -1);
    line(8, 1, 0, -1);
    chk("pre_vs_writes", n_wr, 0);

    // Clean frame A.
    w0 = wq.size();
    vs_pulse();
    for (int l = 0; l < 4; l++) line(8, l, 0, -1);
    vs_pulse();
    chk("a_writes", n_wr - w0, 32);
    chk("a_first_addr", wq[w0], {10'd0, 9'd0});
    chk("a_second_addr", wq[w0 + 1], {10'd1, 9'd0});
    chk("a_line1_addr", wq[w0 + 8], {10'd0, 9'd1});
    chk("a_last_addr", wq[w0 + 31], {10'd7, 9'd3});
    chk("a_fd_count", n_fd, 1);
    chk("a_locked", locked, 1'b1);

    // Frame B: short line at index 1; lines after the error are ignored.
    w0 = n_wr;
    e0 = n_err;
    line(8, 0, 0, -1);
    line(7, 1, 0, -1);
    chk("b_err", n_err - e0, 1);
    chk("b_locked", locked, 1'b0);
    line(8, 2, 0, -1);
    line(8, 3, 0, -1);
    chk("b_writes", n_wr - w0, 15);

    // Frame C: clean recovery.
    vs_pulse();
    for (int l = 0; l < 4; l++) line(8, l, 0, -1);
    vs_pulse();
    chk("c_fd_count", n_fd, 2);
    chk("c_locked", locked, 1'b1);

    // Frame D: 9-pixel line; 9th pixel dropped, err at its line end.
    w0 = n_wr;
    e0 = n_err;
    line(8, 0, 0, -1);
    line(9, 1, 0, -1);
    line(8, 2, 0, -1);
    line(8, 3, 0, -1);
    chk("d_writes", n_wr - w0, 16);
    chk("d_err", n_err - e0, 1);

    // Frame E: only 3 lines before the next vsync.
    vs_pulse();
    e0 = n_err;
    for (int l = 0; l < 3; l++) line(8, l, 0, -1);
    vs_pulse();
    chk("e_err", n_err - e0, 1);
    chk("e_fd_count", n_fd, 2);

    // Frame F resumes at (0,0).
    wf = wq.size();
    for (int l = 0; l < 4; l++) line(8, l, 0, -1);
    chk("f_first_addr", wq[wf], {10'd0, 9'd0});
    chk("f_line1_addr", wq[wf + 8], {10'd0, 9'd1});
    vs_pulse();
    chk("f_fd_count", n_fd, 3);

    // Frame G: reset in the middle of line 1.
    w0 = n_wr;
    line(8, 0, 0, -1);
    line(8, 1, 0, 3);
    chk("g_writes_at_rst", n_wr - w0, 11);
    line(8, 2, 0, -1);
    line(8, 3, 0, -1);
    chk("g_writes_after_rst", n_wr - w0, 11);
    chk("g_fd_count", n_fd, 3);

    // Frame H: all-ones pixels.
    vs_pulse();
    for (int l = 0; l < 4; l++) line(8, l, 1, -1);
    vs_pulse();
    chk("h_fd_count", n_fd, 4);
`ifdef VGA_CAPTURE_SUM_EN
    chk("h_frame_sum", frame_sum, 24'hFFFFE0);
`endif
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
